// File: rtl/hazard_unit_pkg.sv
// Shared definitions for the pipeline hazard unit: result classes, forward codes,
// the "operand unused" Tuse value and the stage/result to forward-code mapping.
package hazard_unit_pkg;

  typedef enum logic [1:0] {
    RES_ALU  = 2'd0,
    RES_DM   = 2'd1,
    RES_PC   = 2'd2,
    RES_HILO = 2'd3
  } res_e;

  typedef enum logic [2:0] {
    FWD_RF    = 3'd0,
    FWD_E_PC  = 3'd1,
    FWD_M_ALU = 3'd2,
    FWD_M_PC  = 3'd3,
    FWD_W_ALU = 3'd4,
    FWD_W_DM  = 3'd5,
    FWD_W_PC  = 3'd6
  } fwd_code_e;

  typedef enum logic [1:0] {
    STG_E = 2'd0,
    STG_M = 2'd1,
    STG_W = 2'd2
  } stage_e;

  localparam logic [1:0] TUSE_UNUSED = 2'd3;
  // Store data travels on source 1 (rt).
  localparam int STORE_SRC = 1;

  // Only the result paths that physically exist in each stage get a code.
  function automatic fwd_code_e fwd_code(input stage_e stg, input res_e res);
    fwd_code = FWD_RF;
    case (stg)
      STG_E: if (res == RES_PC) fwd_code = FWD_E_PC;
      STG_M: begin
        if (res == RES_ALU) fwd_code = FWD_M_ALU;
        else if (res == RES_PC) fwd_code = FWD_M_PC;
      end
      STG_W: begin
        if (res == RES_ALU) fwd_code = FWD_W_ALU;
        else if (res == RES_DM) fwd_code = FWD_W_DM;
        else if (res == RES_PC) fwd_code = FWD_W_PC;
      end
      default: fwd_code = FWD_RF;
    endcase
  endfunction

endpackage

// File: rtl/hazard_unit_md_busy_counter.sv
// Multiply/divide busy countdown: loads on start, counts to zero, one cycle per step.
// busy is combinational from start so the starting cycle already reports busy.
module md_busy_counter #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] load,
  output logic         busy
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (start) begin
      count <= load;
    end else if (count != '0) begin
      count <= count - W'(1);
    end
  end

  assign busy = (count != '0) || start;

endmodule

// File: rtl/hazard_unit.sv
// Stall/forward control from shadow copies of the E/M/W instructions; stall and all
// forward selects are combinational from D inputs and the registered shadow state.
module hazard_unit
  import hazard_unit_pkg::*;
#(
  parameter int NSRC     = 2,
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NSRC*5-1:0] a_d,
  input  logic [NSRC*2-1:0] tuse_d,
  input  logic [4:0]        a3_d,
  input  logic [1:0]        tnew_d,
  input  logic [1:0]        res_d,
  input  logic              md_start_d,
  input  logic              md_kind_d,
  input  logic              md_use_d,
  output logic              stall,
  output logic [NSRC*3-1:0] fwd_d,
  output logic [NSRC*3-1:0] fwd_e,
  output logic [2:0]        fwd_m,
  output logic              md_busy
);

  localparam int MAX_CYC = (MULT_CYC > DIV_CYC) ? MULT_CYC : DIV_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int SSRC    = (NSRC > STORE_SRC) ? STORE_SRC : 0;

  typedef struct packed {
    logic       valid;
    logic [4:0] a3;
    logic [1:0] tnew;
    res_e       res;
  } wb_t;

  typedef struct packed {
    wb_t                  wb;
    logic [NSRC-1:0][4:0] a_src;
    logic                 md_start;
    logic                 md_kind;
  } entry_t;

  // M keeps only the store-data source and W only the writeback info; nothing reads the rest.
  entry_t     d_entry, e_q;
  wb_t        m_q, w_q;
  logic [4:0] m_st_q;
  logic       reg_stall;

  function automatic wb_t age(input wb_t x);
    age = x;
    if (x.tnew != 2'd0) age.tnew = x.tnew - 2'd1;
  endfunction

  function automatic logic hit(input wb_t x, input logic [4:0] a);
    return x.valid && (x.a3 != 5'd0) && (x.a3 == a) && (x.tnew == 2'd0);
  endfunction

  function automatic logic [2:0] pick(input logic [4:0] a, input wb_t e, input wb_t m,
                                      input wb_t w, input logic use_e, input logic use_m);
    logic [2:0] c;
    c = FWD_RF;
    if (a == 5'd0)              c = FWD_RF;
    else if (use_e && hit(e, a)) c = fwd_code(STG_E, e.res);
    else if (use_m && hit(m, a)) c = fwd_code(STG_M, m.res);
    else if (hit(w, a))          c = fwd_code(STG_W, w.res);
    return c;
  endfunction

  always_comb begin
    d_entry          = '0;
    d_entry.wb.valid = 1'b1;
    d_entry.wb.a3    = a3_d;
    d_entry.wb.tnew  = tnew_d;
    d_entry.wb.res   = res_e'(res_d);
    d_entry.a_src    = a_d;
    d_entry.md_start = md_start_d;
    d_entry.md_kind  = md_kind_d;
  end

  always_comb begin
    reg_stall = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (a_d[5*i +: 5] != 5'd0 && tuse_d[2*i +: 2] != TUSE_UNUSED) begin
        if (e_q.wb.valid && e_q.wb.a3 == a_d[5*i +: 5] && e_q.wb.tnew > tuse_d[2*i +: 2])
          reg_stall = 1'b1;
        if (m_q.valid && m_q.a3 == a_d[5*i +: 5] && m_q.tnew > tuse_d[2*i +: 2])
          reg_stall = 1'b1;
      end
    end
  end

  // md_busy already folds in E.md_start, covering the cycle before the counter loads.
  assign stall = reg_stall || (md_use_d && md_busy);

  always_comb begin
    fwd_d = '0;
    fwd_e = '0;
    for (int i = 0; i < NSRC; i++) begin
      fwd_d[3*i +: 3] = pick(a_d[5*i +: 5], e_q.wb, m_q, w_q, 1'b1, 1'b1);
      fwd_e[3*i +: 3] = pick(e_q.a_src[i], e_q.wb, m_q, w_q, 1'b0, 1'b1);
    end
  end

  assign fwd_m = pick(m_st_q, e_q.wb, m_q, w_q, 1'b0, 1'b0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      e_q    <= '0;
      m_q    <= '0;
      m_st_q <= '0;
      w_q    <= '0;
    end else begin
      if (stall) e_q <= '0;
      else       e_q <= d_entry;
      m_q    <= age(e_q.wb);
      m_st_q <= e_q.a_src[SSRC];
      w_q    <= age(m_q);
    end
  end

  md_busy_counter #(.W(CW)) u_md_busy_counter (
    .clk   (clk),
    .reset (reset),
    .start (e_q.md_start),
    .load  (e_q.md_kind ? CW'(DIV_CYC) : CW'(MULT_CYC)),
    .busy  (md_busy)
  );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed scenarios plus a randomized run against an age-based pipeline model.
module tb_hazard_unit;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;
  localparam logic [1:0] ALU = 2'd0, DM = 2'd1, PC = 2'd2, HILO = 2'd3;

  logic       clk;
  logic       reset;
  logic [9:0] a_d;
  logic [3:0] tuse_d;
  logic [4:0] a3_d;
  logic [1:0] tnew_d, res_d;
  logic       md_start_d, md_kind_d, md_use_d;
  logic       stall, md_busy;
  logic [5:0] fwd_d, fwd_e;
  logic [2:0] fwd_m;

  int n_vec;
  int n_fail;

  hazard_unit #(.NSRC(2), .MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk(clk), .reset(reset), .a_d(a_d), .tuse_d(tuse_d), .a3_d(a3_d),
    .tnew_d(tnew_d), .res_d(res_d), .md_start_d(md_start_d), .md_kind_d(md_kind_d),
    .md_use_d(md_use_d), .stall(stall), .fwd_d(fwd_d), .fwd_e(fwd_e),
    .fwd_m(fwd_m), .md_busy(md_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic       valid;
    logic [4:0] a3;
    int         tnew;
    int         res;
    logic [4:0] src0;
    logic [4:0] src1;
    logic       mds;
    logic       mdk;
  } ins_t;

  ins_t pipe [3];  // index = stages past D: 0 E, 1 M, 2 W
  int   cyc;
  int   busy_until;
  int   fwd_tbl [3][4] = '{'{0, 0, 1, 0}, '{2, 0, 3, 0}, '{4, 5, 6, 0}};

  function automatic ins_t empty_ins();
    ins_t x;
    x.valid = 1'b0; x.a3 = 5'd0; x.tnew = 0; x.res = 0;
    x.src0 = 5'd0; x.src1 = 5'd0; x.mds = 1'b0; x.mdk = 1'b0;
    return x;
  endfunction

  function automatic int tnew_at(input ins_t x, input int k);
    return (x.tnew > k) ? x.tnew - k : 0;
  endfunction

  function automatic int model_fwd(input logic [4:0] a, input int first);
    if (a == 5'd0) return 0;
    for (int k = first; k < 3; k++)
      if (pipe[k].valid && pipe[k].a3 != 5'd0 && pipe[k].a3 == a && tnew_at(pipe[k], k) == 0)
        return fwd_tbl[k][pipe[k].res];
    return 0;
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic drive(input logic [4:0] s0, input logic [1:0] u0, input logic [4:0] s1,
                       input logic [1:0] u1, input logic [4:0] a3, input logic [1:0] tn,
                       input logic [1:0] rs, input logic mds, input logic mdk, input logic mdu);
    a_d = {s1, s0}; tuse_d = {u1, u0}; a3_d = a3; tnew_d = tn; res_d = rs;
    md_start_d = mds; md_kind_d = mdk; md_use_d = mdu;
  endtask

  task automatic nop();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd0, 2'd0, ALU, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic do_reset();
    nop();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    drive(5'd5, 2'd0, 5'd6, 2'd0, 5'd7, 2'd2, DM, 1'b1, 1'b1, 1'b1);
    step();
    step();
    #1;
    n_vec++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset stall: got %b want 0", stall); end
    n_vec++; if (md_busy !== 1'b0) begin n_fail++; $display("FAIL reset md_busy: got %b want 0", md_busy); end
    n_vec++; if ({fwd_d, fwd_e, fwd_m} !== 15'd0) begin
      n_fail++; $display("FAIL reset fwd: got d=%h e=%h m=%h want 0", fwd_d, fwd_e, fwd_m);
    end
    reset = 1'b0;
    step();
  endtask

  task automatic test_lw_beq();
    do_reset();
    drive(5'd29, 2'd1, 5'd0, 2'd3, 5'd1, 2'd2, DM, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw issue stall: got %b want 0", stall); end
    step();
    drive(5'd1, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, ALU, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      #1;
      n_vec++; if (stall !== 1'b1) begin n_fail++; $display("FAIL lw_beq stall c%0d: got %b want 1", k, stall); end
      step();
    end
    #1;
    n_vec++; if (stall !== 1'b0) begin n_fail++; $display("FAIL lw_beq release: got %b want 0", stall); end
    n_vec++; if (fwd_d !== 6'o05) begin n_fail++; $display("FAIL lw_beq fwd_d: got %o want 05", fwd_d); end
    step();
  endtask

  task automatic test_alu_fwd();
    do_reset();
    drive(5'd4, 2'd1, 5'd5, 2'd1, 5'd2, 2'd1, ALU, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd2, 2'd1, 5'd0, 2'd1, 5'd6, 2'd1, ALU, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_fail++; $display("FAIL alu stall: got %b want 0", stall); end
    step();
    drive(5'd0, 2'd1, 5'd6, 2'd2, 5'd0, 2'd0, ALU, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_fail++; $display("FAIL sw stall: got %b want 0", stall); end
    n_vec++; if (fwd_e !== 6'o02) begin n_fail++; $display("FAIL alu fwd_e: got %o want 02", fwd_e); end
    step();
    nop();
    #1;
    n_vec++; if (fwd_e !== 6'o20) begin n_fail++; $display("FAIL sw fwd_e: got %o want 20", fwd_e); end
    step();
    #1;
    n_vec++; if (fwd_m !== 3'd4) begin n_fail++; $display("FAIL sw fwd_m: got %0d want 4", fwd_m); end
    step();
  endtask

  task automatic test_jal_jr();
    do_reset();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd31, 2'd0, PC, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd31, 2'd0, 5'd0, 2'd3, 5'd0, 2'd0, ALU, 1'b0, 1'b0, 1'b0);
    #1;
    n_vec++; if (stall !== 1'b0) begin n_fail++; $display("FAIL jr stall: got %b want 0", stall); end
    n_vec++; if (fwd_d !== 6'o01) begin n_fail++; $display("FAIL jr fwd_d: got %o want 01", fwd_d); end
    step();
  endtask

  task automatic test_div_mflo();
    int   cycles;
    logic last_busy;
    do_reset();
    drive(5'd8, 2'd1, 5'd9, 2'd1, 5'd0, 2'd0, ALU, 1'b1, 1'b1, 1'b1);
    #1;
    n_vec++; if (stall !== 1'b0 || md_busy !== 1'b0) begin
      n_fail++; $display("FAIL div issue: got stall=%b busy=%b want 0 0", stall, md_busy);
    end
    step();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd3, 2'd1, HILO, 1'b0, 1'b0, 1'b1);
    cycles = 0;
    last_busy = 1'b0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (stall !== 1'b1) break;
      cycles++;
      last_busy = md_busy;
      step();
    end
    n_vec++; if (cycles != 1 + DIV_N) begin
      n_fail++; $display("FAIL div_mflo stall cycles: got %0d want %0d", cycles, 1 + DIV_N);
    end
    n_vec++; if (md_busy !== 1'b0 || last_busy !== 1'b1) begin
      n_fail++; $display("FAIL div_mflo busy edge: got now=%b prev=%b want 0 1", md_busy, last_busy);
    end
    step();
  endtask

  task automatic test_zero_reg();
    do_reset();
    drive(5'd0, 2'd1, 5'd0, 2'd3, 5'd0, 2'd2, DM, 1'b0, 1'b0, 1'b0);
    step();
    drive(5'd0, 2'd0, 5'd0, 2'd0, 5'd0, 2'd0, PC, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      #1;
      n_vec++; if (stall !== 1'b0) begin n_fail++; $display("FAIL zero stall c%0d: got %b want 0", k, stall); end
      n_vec++; if ({fwd_d, fwd_e, fwd_m} !== 15'd0) begin
        n_fail++; $display("FAIL zero fwd c%0d: got d=%o e=%o m=%0d want 0", k, fwd_d, fwd_e, fwd_m);
      end
      step();
    end
  endtask

  task automatic test_reset_mid_mult();
    do_reset();
    drive(5'd4, 2'd1, 5'd5, 2'd1, 5'd0, 2'd0, ALU, 1'b1, 1'b0, 1'b1);
    step();
    nop();
    #1;
    n_vec++; if (md_busy !== 1'b1) begin n_fail++; $display("FAIL mult start busy: got %b want 1", md_busy); end
    step(); step(); step();
    drive(5'd0, 2'd3, 5'd0, 2'd3, 5'd7, 2'd1, HILO, 1'b0, 1'b0, 1'b1);
    #1;
    n_vec++; if (stall !== 1'b1 || md_busy !== 1'b1) begin
      n_fail++; $display("FAIL mult count3: got stall=%b busy=%b want 1 1", stall, md_busy);
    end
    reset = 1'b1;
    #1;
    n_vec++; if (stall !== 1'b0 || md_busy !== 1'b0) begin
      n_fail++; $display("FAIL async reset: got stall=%b busy=%b want 0 0", stall, md_busy);
    end
    #1;
    reset = 1'b0;
    #1;
    n_vec++; if (stall !== 1'b0 || md_busy !== 1'b0) begin
      n_fail++; $display("FAIL post reset: got stall=%b busy=%b want 0 0", stall, md_busy);
    end
    step();
  endtask

  task automatic test_random();
    ins_t       d;
    logic [4:0] s0, s1, a3;
    logic [1:0] u0, u1, tn, rs;
    logic       mds, mdk, mdu, exp_busy, exp_stall;
    logic [5:0] exp_fd, exp_fe;
    logic [2:0] exp_fm;
    do_reset();
    for (int k = 0; k < 3; k++) pipe[k] = empty_ins();
    cyc = 0;
    busy_until = -1;
    for (int n = 0; n < 600; n++) begin
      s0 = 5'($urandom_range(0, 3)); s1 = 5'($urandom_range(0, 3));
      u0 = 2'($urandom_range(0, 3)); u1 = 2'($urandom_range(0, 3));
      a3 = 5'($urandom_range(0, 3)); tn = 2'($urandom_range(0, 2));
      rs = 2'($urandom_range(0, 3));
      mds = ($urandom_range(0, 9) == 0);
      mdk = 1'($urandom_range(0, 1));
      mdu = mds | ($urandom_range(0, 7) == 0);
      drive(s0, u0, s1, u1, a3, tn, rs, mds, mdk, mdu);
      d.valid = 1'b1; d.a3 = a3; d.tnew = int'(tn); d.res = int'(rs);
      d.src0 = s0; d.src1 = s1; d.mds = mds; d.mdk = mdk;
      #1;
      exp_busy  = (cyc <= busy_until) || (pipe[0].valid && pipe[0].mds);
      exp_stall = mdu && exp_busy;
      for (int k = 0; k < 2; k++) begin
        if (pipe[k].valid && s0 != 5'd0 && u0 != 2'd3 && pipe[k].a3 == s0 && tnew_at(pipe[k], k) > int'(u0))
          exp_stall = 1'b1;
        if (pipe[k].valid && s1 != 5'd0 && u1 != 2'd3 && pipe[k].a3 == s1 && tnew_at(pipe[k], k) > int'(u1))
          exp_stall = 1'b1;
      end
      exp_fd = {3'(model_fwd(s1, 0)), 3'(model_fwd(s0, 0))};
      exp_fe = {3'(model_fwd(pipe[0].src1, 1)), 3'(model_fwd(pipe[0].src0, 1))};
      exp_fm = 3'(model_fwd(pipe[1].src1, 2));
      n_vec++; if (stall !== exp_stall) begin
        n_fail++; $display("FAIL rnd stall cyc %0d: got %b want %b", cyc, stall, exp_stall);
      end
      n_vec++; if (md_busy !== exp_busy) begin
        n_fail++; $display("FAIL rnd md_busy cyc %0d: got %b want %b", cyc, md_busy, exp_busy);
      end
      n_vec++; if (fwd_d !== exp_fd) begin
        n_fail++; $display("FAIL rnd fwd_d cyc %0d: got %o want %o", cyc, fwd_d, exp_fd);
      end
      n_vec++; if (fwd_e !== exp_fe) begin
        n_fail++; $display("FAIL rnd fwd_e cyc %0d: got %o want %o", cyc, fwd_e, exp_fe);
      end
      n_vec++; if (fwd_m !== exp_fm) begin
        n_fail++; $display("FAIL rnd fwd_m cyc %0d: got %0d want %0d", cyc, fwd_m, exp_fm);
      end
      step();
      if (pipe[0].valid && pipe[0].mds) busy_until = cyc + (pipe[0].mdk ? DIV_N : MULT_N);
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = exp_stall ? empty_ins() : d;
      cyc++;
    end
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;
    reset  = 1'b0;
    nop();
    test_reset();
    test_lw_beq();
    test_alu_fwd();
    test_jal_jr();
    test_div_mflo();
    test_zero_reg();
    test_reset_mid_mult();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
